// File: rtl/lrhls_mul_arbiter.sv
// ---------------------------------------------------------------------------
// lrhls_mul_arbiter
//
// Shares one 17-bit unsigned x 18-bit signed multiplier among NUM_REQ
// requesters. A round-robin arbiter grants at most one request per cycle.
// The granted operands are registered in stage S1 and multiplied. The
// 33-bit product is registered in stage S2 and returned on a single result
// channel, tagged with the index of the requester that owns it.
//
// Ports
//   ap_clk     in   clock
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]      per-requester request valid
//   req_ready  out  [NUM_REQ]      per-requester accept (at most one bit set)
//   req_a      in   [NUM_REQ*17]   unsigned operand A, requester i at [17i+:17]
//   req_b      in   [NUM_REQ*18]   signed operand B, requester i at [18i+:18]
//   res_valid  out                 result valid
//   res_ready  in                  downstream accepts result
//   res_id     out  [ID_W]         owner of the result
//   res_p      out  [33]           signed product, truncated to 33 bits
// ---------------------------------------------------------------------------
module lrhls_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*17-1:0]   req_a,
  input  logic [NUM_REQ*18-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [32:0]             res_p
);

  localparam int A_W = 17;
  localparam int B_W = 18;
  localparam int P_W = 33;

  // Requester 0 gets first priority after reset.
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);
  // One extra bit so last + k never overflows before the modulo fold.
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  // Stage S1: granted operands
  logic            v1_q, v1_d;
  logic [ID_W-1:0] id1_q, id1_d;
  logic [A_W-1:0]  a1_q, a1_d;
  logic [B_W-1:0]  b1_q, b1_d;

  // Stage S2: product
  logic            v2_q, v2_d;
  logic [ID_W-1:0] id2_q, id2_d;
  logic [P_W-1:0]  p2_q, p2_d;

  // Round-robin pointer: most recently granted requester
  logic [ID_W-1:0] last_q, last_d;

  logic            adv1_s, adv2_s, accept_s, grant_s;
  logic            any_s;
  logic [ID_W-1:0] win_s;
  logic [P_W-1:0]  a_ext_s, b_ext_s, prod_s;

  assign adv2_s   = ~v2_q | res_ready;
  assign adv1_s   = ~v1_q | adv2_s;
  assign accept_s = adv1_s & ~ap_rst;
  assign grant_s  = accept_s & any_s;

  // Both operands are widened to 33 bits; a 33-bit product of the widened
  // values equals the low 33 bits of the exact signed product.
  assign a_ext_s = {16'd0, a1_q};
  assign b_ext_s = {{15{b1_q[B_W-1]}}, b1_q};
  assign prod_s  = $signed(a_ext_s) * $signed(b_ext_s);

  // Round-robin search: last+1, last+2, ... wrapping, ending at last itself
  always_comb begin : arb_search
    logic [ID_W:0] sum;
    logic [ID_W:0] idx;
    sum   = '0;
    idx   = '0;
    any_s = 1'b0;
    win_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_q} + (ID_W + 1)'(k);
      if (sum >= NUM_REQ_W) begin
        idx = sum - NUM_REQ_W;
      end else begin
        idx = sum;
      end
      if (!any_s && req_valid[idx[ID_W-1:0]]) begin
        any_s = 1'b1;
        win_s = idx[ID_W-1:0];
      end else begin
        any_s = any_s;
      end
    end
  end

  // Accept strobe: one-hot of the winner, only when the pipeline can take it
  always_comb begin
    req_ready = '0;
    if (grant_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for both pipeline stages and the arbitration pointer
  always_comb begin
    v1_d   = v1_q;
    id1_d  = id1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    v2_d   = v2_q;
    id2_d  = id2_q;
    p2_d   = p2_q;
    last_d = last_q;

    if (adv2_s) begin
      v2_d  = v1_q;
      id2_d = id1_q;
      p2_d  = prod_s;
    end else begin
      v2_d  = v2_q;
    end

    if (adv1_s) begin
      v1_d = grant_s;
      if (grant_s) begin
        id1_d  = win_s;
        a1_d   = req_a[A_W*win_s +: A_W];
        b1_d   = req_b[B_W*win_s +: B_W];
        last_d = win_s;
      end else begin
        last_d = last_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // State registers with synchronous reset; in-flight work is discarded
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_q   <= 1'b0;
      id1_q  <= '0;
      a1_q   <= '0;
      b1_q   <= '0;
      v2_q   <= 1'b0;
      id2_q  <= '0;
      p2_q   <= '0;
      last_q <= LAST_RST;
    end else begin
      v1_q   <= v1_d;
      id1_q  <= id1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      v2_q   <= v2_d;
      id2_q  <= id2_d;
      p2_q   <= p2_d;
      last_q <= last_d;
    end
  end

  assign res_valid = v2_q;
  assign res_id    = id2_q;
  assign res_p     = p2_q;

endmodule

// File: tb/tb_lrhls_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lrhls_mul_arbiter
//
// Directed bench for lrhls_mul_arbiter (NUM_REQ = 4). The stimulus process
// pushes the hand-computed {id, product} of every expected handshake into a
// scoreboard queue; an independent monitor pops and compares whenever a
// result transfers. Grant one-hots and pipeline status are checked inline.
// ---------------------------------------------------------------------------
module tb_lrhls_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [67:0] req_a;
  logic [71:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [32:0] res_p;

  typedef struct packed {
    logic [1:0]  id;
    logic [32:0] p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Hand-computed products for the operand set loaded below
  localparam logic [32:0] P0 = 33'h1_FFFF_FED4; // 100 * -3 = -300
  localparam logic [32:0] P1 = 33'h1_FFFC_0001; // 131071 * 131071, low 33 bits
  localparam logic [32:0] P2 = 33'h0_0000_0000; // 0 * -131072
  localparam logic [32:0] P3 = 33'h0_0000_0023; // 5 * 7 = 35

  always #5 ap_clk = ~ap_clk;

  lrhls_mul_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [32:0] p);
    exp_t e;
    e.id = id;
    e.p  = p;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [16:0] a, input logic [17:0] b);
    req_a[17*i +: 17] = a;
    req_b[18*i +: 18] = b;
  endtask

  // Let the pipeline empty, then realign to a falling edge
  task automatic drain();
    req_valid = 4'b0000;
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      #3;
      if (sb.size() == 0 && !res_valid) break;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge ap_clk);
  endtask

  // Monitor: samples just before the next rising edge, after stimulus settles
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      #2;
      if (!ap_rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d p %0h, expected no result", res_id, res_p);
        end else begin
          e = sb.pop_front();
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_p", 64'(res_p), 64'(e.p));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] oh;
    logic [3:0] bp_exp [5];
    bp_exp[0] = 4'b1000;
    bp_exp[1] = 4'b0010;
    bp_exp[2] = 4'b0000;
    bp_exp[3] = 4'b0000;
    bp_exp[4] = 4'b0000;

    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    set_op(0, 17'd100,   18'h3FFFD);
    set_op(1, 17'h1FFFF, 18'h1FFFF);
    set_op(2, 17'd0,     18'h20000);
    set_op(3, 17'd5,     18'd7);

    // Reset with everyone requesting: nothing accepted, nothing produced
    repeat (3) begin
      @(negedge ap_clk);
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
    end
    ap_rst = 1'b0;

    // Fairness: all four valid, grants rotate starting at requester 0
    for (int c = 0; c < 8; c++) begin
      #1;
      oh = 4'b0001 << (c % 4);
      check("rr_grant", 64'(req_ready), 64'(oh));
      case (c % 4)
        0:       push(2'd0, P0);
        1:       push(2'd1, P1);
        2:       push(2'd2, P2);
        3:       push(2'd3, P3);
        default: push(2'd0, P0);
      endcase
      if (c >= 2) check("rr_back_to_back", 64'(res_valid), 64'd1);
      @(negedge ap_clk);
    end
    drain();

    // Basic product from requester 2 alone, with latency check
    set_op(2, 17'd100, 18'h3FFFD);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    #1;
    check("basic_grant", 64'(req_ready), 64'b0100);
    push(2'd2, P0);
    @(negedge ap_clk);
    req_valid = 4'b0000;
    #1;
    check("basic_lat1", 64'(res_valid), 64'd0);
    @(negedge ap_clk);
    #1;
    check("basic_lat2_valid", 64'(res_valid), 64'd1);
    check("basic_lat2_id", 64'(res_id), 64'd2);
    check("basic_lat2_p", 64'(res_p), 64'(P0));
    set_op(2, 17'd0, 18'h20000);
    drain();

    // Backpressure: requesters 1 and 3 valid, result channel blocked
    res_ready = 1'b0;
    req_valid = 4'b1010;
    for (int b = 0; b < 5; b++) begin
      #1;
      check("bp_grant", 64'(req_ready), 64'(bp_exp[b]));
      if (b == 0) push(2'd3, P3);
      if (b == 1) push(2'd1, P1);
      if (b >= 2) begin
        check("bp_hold_valid", 64'(res_valid), 64'd1);
        check("bp_hold_id", 64'(res_id), 64'd3);
        check("bp_hold_p", 64'(res_p), 64'(P3));
      end
      @(negedge ap_clk);
    end
    // Release: drain and new grant in the same cycle; pointer held at 1
    res_ready = 1'b1;
    #1;
    check("bp_no_bubble", 64'(req_ready), 64'b1000);
    push(2'd3, P3);
    @(negedge ap_clk);
    drain();

    // Reset mid-flight: fill both stages, reset, nothing stale comes out
    res_ready = 1'b0;
    req_valid = 4'b0101;
    #1;
    check("mf_grant0", 64'(req_ready), 64'b0001);
    @(negedge ap_clk);
    #1;
    check("mf_grant1", 64'(req_ready), 64'b0100);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check("mf_rst_ready", 64'(req_ready), 64'd0);
    check("mf_full", 64'(res_valid), 64'd1);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    res_ready = 1'b1;
    #1;
    check("mf_res_valid", 64'(res_valid), 64'd0);
    check("mf_restart", 64'(req_ready), 64'b0001);
    push(2'd0, P0);
    @(negedge ap_clk);
    #1;
    check("mf_next", 64'(req_ready), 64'b0100);
    push(2'd2, P2);
    @(negedge ap_clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
